rgb_fade_sequencer: RTL and testbench
=====================================

# rgb_fade_sequencer

Sequencer for the RGB LED duty-cycle datapath. It runs a configurable fade engine and drives the three 8-bit duty values consumed by the PWM stage. It supports start, stop and pause control, mode selection, per-step prescaling and saturating step arithmetic. It sits between the board control inputs (buttons/switches) and the per-channel PWM comparators.

## Interface
- `STEP_DIV`, default 625000: clk cycles per fade step (≥2).
- `STEP`, default 1: level increment/decrement per step (1..255).
- `MAX_LEVEL`, default 255: peak duty level (STEP..255).
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: start request, sampled only in IDLE.
- `stop` in 1: abort to IDLE; highest priority.
- `pause` in 1: level-sensitive freeze of prescaler, state and level.
- `mode` in 2: 0 = R→G→B cycle, 1 = R only, 2 = white (R=G=B), 3 = reserved (start ignored). Latched at start.
- `R_time_out`, `G_time_out`, `B_time_out` out 8: registered duty values.
- `busy` out 1: high in any state other than IDLE.
- `phase` out 2: active channel (0 = R, 1 = G, 2 = B).
- `cycle_done` out 1: one-cycle pulse at the end of a full pattern cycle.
- `pwm_r`, `pwm_g`, `pwm_b` out 1: PWM pins (see Configuration).

## Operation
- States: IDLE, RISE, FALL.
- Internal registers: `level` (8-bit), `ch` (2-bit), latched mode, prescaler `cnt`.
- `step_tick` is high in the cycle where `cnt == STEP_DIV-1`. `cnt` wraps to 0 on that cycle.
- IDLE:
  - All duty outputs, `level`, `ch` and `cnt` are 0.
  - On `start` with mode ≠ 3: go to RISE, latch mode, `ch` = 0, `cnt` = 0.
- RISE, on `step_tick`:
  - `level` = min(`level` + STEP, MAX_LEVEL), computed 9-bit and saturated.
  - When the new level equals MAX_LEVEL, go to FALL on the same edge.
- FALL, on `step_tick`:
  - `level` = max(`level` − STEP, 0), with no underflow.
  - When the new level is 0, go to RISE on the same edge and advance per mode:
    - Mode 0: `ch` advances 0→1→2→0. `cycle_done` pulses when leaving `ch` = 2.
    - Mode 1: `ch` stays 0. `cycle_done` pulses on every fall completion.
    - Mode 2: `ch` stays 0. `cycle_done` pulses on every fall completion.
- Output mapping:
  - Modes 0 and 1: the channel selected by `ch` gets `level`; the other channels get 0.
  - Mode 2: all three channels get `level`.
- `pause` high: `cnt`, `level`, `ch` and state all hold, and no `step_tick` is generated. `pause` has no effect in IDLE.
- `stop`: next edge goes to IDLE with all outputs 0, regardless of state, `start` or `pause`.
- `start` while busy is ignored. `mode` changes while busy are ignored.

## Timing
- All outputs are registered.
- Reset values: `R_time_out`, `G_time_out`, `B_time_out`, `phase`, `busy`, `cycle_done` and `pwm_*` are all 0.
- `rst` mid-operation: IDLE and all outputs 0 after the next edge.
- Start latency:
  - `start` sampled at edge N sets `busy` = 1 after edge N, with `level` = 0.
  - The first level change is visible STEP_DIV cycles later.
- Duty outputs change only on the edge that consumes a `step_tick`.
- `cycle_done` is high for exactly one cycle, coincident with the duty update to 0.
- A full single-channel breath with STEP = 1 and MAX_LEVEL = 255 takes 510 steps.

## Configuration
- Macro `RGB_FADE_PWM_OUT_EN`.
- Defined:
  - Adds an 8-bit free-running `pwm_cnt` counting 0..254 (period 255 clk), reset to 0.
  - `pwm_x` = (`pwm_cnt` < duty_x), registered.
  - Duty 0 gives a constantly low output; duty 255 gives a constantly high output.
- Undefined: the PWM counter is not present and `pwm_r`, `pwm_g`, `pwm_b` are tied to 0. Ports remain present.

## Structure
- Package `rgb_fade_pkg` holds:
  - The state enum (IDLE/RISE/FALL).
  - The mode encodings (MODE_CYCLE, MODE_RED, MODE_WHITE, MODE_RSVD).
  - The channel encodings (CH_R, CH_G, CH_B).
- Sub-module `rgb_step_prescaler`:
  - Parameter STEP_DIV.
  - Inputs `clk`, `rst`, `clr`, `hold`; output `step_tick`.
  - `clr` has priority over `hold`.

## Test plan
- STEP_DIV=4, STEP=2, MAX_LEVEL=8, mode 1, `start` pulse → R_time_out steps 0,2,4,6,8,6,4,2,0 every 4 cycles; G and B stay 0; `cycle_done` pulses 32 cycles after `busy` rises.
- Same parameters, mode 0 → R, G, B breathe in turn with `phase` 0,1,2; a single `cycle_done` pulse when B returns to 0; then `phase` = 0 and R rises again.
- STEP=3, MAX_LEVEL=8, mode 2 → R=G=B stepping 0,3,6,8,5,2,0 (saturation at both ends).
- `pause` held for 10 cycles mid-RISE → outputs and `phase` frozen; on release, the next step arrives after the remaining prescaler count.
- `stop` asserted together with `start` and `pause` during FALL → IDLE next edge, all outputs 0, `busy` = 0. `start` with mode 3 → remains IDLE.
- With `RGB_FADE_PWM_OUT_EN` defined, force duty 0, 128 and 255 → `pwm_r` high for 0, 128 and 255 of every 255 cycles respectively.

Source files
------------

// File: rtl/rgb_fade_pkg.sv
// Shared types and encodings for the RGB fade sequencer.
// Optional PWM pin drivers are enabled with RGB_FADE_PWM_OUT_EN.
package rgb_fade_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2
    } fade_state_t;

    localparam logic [1:0] MODE_CYCLE = 2'd0;
    localparam logic [1:0] MODE_RED   = 2'd1;
    localparam logic [1:0] MODE_WHITE = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    function automatic logic [1:0] next_ch(input logic [1:0] c);
        return (c == CH_B) ? CH_R : c + 2'd1;
    endfunction

endpackage

// File: rtl/rgb_fade_sequencer_prescaler.sv
// Fade step prescaler: one step_tick every STEP_DIV unheld cycles.
// clr wins over hold so an abort always restarts the count.
module rgb_step_prescaler #(
    parameter int STEP_DIV = 625000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic step_tick
);

    localparam int CW = $clog2(STEP_DIV);
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign step_tick = !clr && !hold && (cnt == LAST);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// RGB fade engine driving three registered 8-bit duty values.
// Define RGB_FADE_PWM_OUT_EN to drive pwm_r/g/b from an internal counter.
module rgb_fade_sequencer
    import rgb_fade_pkg::*;
#(
    parameter int STEP_DIV  = 625000,
    parameter int STEP      = 1,
    parameter int MAX_LEVEL = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [1:0] mode,
    output logic [7:0] R_time_out,
    output logic [7:0] G_time_out,
    output logic [7:0] B_time_out,
    output logic       busy,
    output logic [1:0] phase,
    output logic       cycle_done,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b
);

    fade_state_t state, state_n;
    logic [7:0]  level, level_n;
    logic [1:0]  ch, ch_n;
    logic [1:0]  mode_q, mode_n;
    logic        done_n;
    logic [7:0]  r_n, g_n, b_n;
    logic [8:0]  sum;
    logic        step_tick;
    logic        pre_clr;
    logic        pre_hold;

    assign pre_clr  = stop || (state == ST_IDLE);
    assign pre_hold = pause && (state != ST_IDLE);

    rgb_step_prescaler #(
        .STEP_DIV(STEP_DIV)
    ) u_pre (
        .clk      (clk),
        .rst      (rst),
        .clr      (pre_clr),
        .hold     (pre_hold),
        .step_tick(step_tick)
    );

    assign sum = {1'b0, level} + 9'(STEP);

    always_comb begin
        state_n = state;
        level_n = level;
        ch_n    = ch;
        mode_n  = mode_q;
        done_n  = 1'b0;
        if (stop) begin
            state_n = ST_IDLE;
            level_n = '0;
            ch_n    = CH_R;
        end else begin
            case (state)
                ST_IDLE: begin
                    level_n = '0;
                    ch_n    = CH_R;
                    if (start && (mode != MODE_RSVD)) begin
                        state_n = ST_RISE;
                        mode_n  = mode;
                    end
                end
                ST_RISE: begin
                    if (step_tick) begin
                        if (sum >= 9'(MAX_LEVEL)) begin
                            level_n = 8'(MAX_LEVEL);
                            state_n = ST_FALL;
                        end else begin
                            level_n = sum[7:0];
                        end
                    end
                end
                ST_FALL: begin
                    if (step_tick) begin
                        if (level <= 8'(STEP)) begin
                            level_n = '0;
                            state_n = ST_RISE;
                            if (mode_q == MODE_CYCLE) begin
                                ch_n   = next_ch(ch);
                                done_n = (ch == CH_B);
                            end else begin
                                done_n = 1'b1;
                            end
                        end else begin
                            level_n = level - 8'(STEP);
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Duty mapping is computed from next-state values so outputs stay registered
    always_comb begin
        r_n = '0;
        g_n = '0;
        b_n = '0;
        if (mode_n == MODE_WHITE) begin
            r_n = level_n;
            g_n = level_n;
            b_n = level_n;
        end else begin
            case (ch_n)
                CH_R:    r_n = level_n;
                CH_G:    g_n = level_n;
                CH_B:    b_n = level_n;
                default: r_n = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            level      <= '0;
            ch         <= CH_R;
            mode_q     <= MODE_CYCLE;
            R_time_out <= '0;
            G_time_out <= '0;
            B_time_out <= '0;
            busy       <= 1'b0;
            phase      <= CH_R;
            cycle_done <= 1'b0;
        end else begin
            state      <= state_n;
            level      <= level_n;
            ch         <= ch_n;
            mode_q     <= mode_n;
            R_time_out <= r_n;
            G_time_out <= g_n;
            B_time_out <= b_n;
            busy       <= (state_n != ST_IDLE);
            phase      <= ch_n;
            cycle_done <= done_n;
        end
    end

`ifdef RGB_FADE_PWM_OUT_EN
    logic [7:0] pwm_cnt;

    // Period 255 so duty 255 is solidly on and duty 0 solidly off
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            pwm_r   <= 1'b0;
            pwm_g   <= 1'b0;
            pwm_b   <= 1'b0;
        end else begin
            pwm_cnt <= (pwm_cnt == 8'd254) ? '0 : pwm_cnt + 8'd1;
            pwm_r   <= (pwm_cnt < R_time_out);
            pwm_g   <= (pwm_cnt < G_time_out);
            pwm_b   <= (pwm_cnt < B_time_out);
        end
    end
`else
    assign pwm_r = 1'b0;
    assign pwm_g = 1'b0;
    assign pwm_b = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Scoreboard bench for rgb_fade_sequencer with a step-count reference model.
// Honours RGB_FADE_PWM_OUT_EN for the expected pwm pins.
module tb_rgb_fade_sequencer;

    localparam int SD  = 4;
    localparam int STP = 3;
    localparam int MX  = 8;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       busy;
        logic [1:0] phase;
        logic       done;
        logic       pr;
        logic       pg;
        logic       pb;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] r_out, g_out, b_out;
    logic       busy, cycle_done;
    logic [1:0] phase;
    logic       pwm_r, pwm_g, pwm_b;

    int total = 0;
    int bad = 0;
    bit running = 1'b1;

    obs_t q[$];
    int   seq[$];
    int   blen;

    bit         active = 1'b0;
    int         t = 0;
    logic [1:0] mm = 2'd0;
    int         pc = 0;
    obs_t       prev_e = '0;

    always #5 clk = ~clk;

    rgb_fade_sequencer #(
        .STEP_DIV (SD),
        .STEP     (STP),
        .MAX_LEVEL(MX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .mode      (mode),
        .R_time_out(r_out),
        .G_time_out(g_out),
        .B_time_out(b_out),
        .busy      (busy),
        .phase     (phase),
        .cycle_done(cycle_done),
        .pwm_r     (pwm_r),
        .pwm_g     (pwm_g),
        .pwm_b     (pwm_b)
    );

    // Reference: level is a function of steps taken, steps of unpaused cycles
    always @(posedge clk) begin
        obs_t e;
        bit   inc;
        int   n, c, lv;
        if (running) begin
            inc = 1'b0;
            if (rst || stop) begin
                active = 1'b0;
                t = 0;
            end else if (!active) begin
                if (start && mode != 2'd3) begin
                    active = 1'b1;
                    mm = mode;
                    t = 0;
                end
            end else if (!pause) begin
                t++;
                inc = 1'b1;
            end
            e = '0;
            if (active) begin
                n  = t / SD;
                lv = seq[n % blen];
                c  = (mm == 2'd0) ? (n / blen) % 3 : 0;
                e.busy  = 1'b1;
                e.phase = 2'(c);
                if (mm == 2'd2) begin
                    e.r = 8'(lv);
                    e.g = 8'(lv);
                    e.b = 8'(lv);
                end else if (c == 0) e.r = 8'(lv);
                else if (c == 1) e.g = 8'(lv);
                else e.b = 8'(lv);
                e.done = inc && (t % SD == 0) && (n % blen == 0)
                    && (mm != 2'd0 || (n / blen) % 3 == 0);
            end
`ifdef RGB_FADE_PWM_OUT_EN
            if (rst) begin
                pc = 0;
            end else begin
                e.pr = (pc < int'(prev_e.r));
                e.pg = (pc < int'(prev_e.g));
                e.pb = (pc < int'(prev_e.b));
                pc = (pc == 254) ? 0 : pc + 1;
            end
`endif
            prev_e = e;
            q.push_back(e);
        end
    end

    always begin
        obs_t w, g;
        @(posedge clk);
        #1;
        if (running) begin
            g = '{r_out, g_out, b_out, busy, phase, cycle_done,
                  pwm_r, pwm_g, pwm_b};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty: no expected entry at t=%0t", $time);
            end else begin
                w = q.pop_front();
                if (g !== w) begin
                    bad++;
                    $display("FAIL obs t=%0t got r=%0d g=%0d b=%0d busy=%b ph=%0d done=%b pwm=%b%b%b want r=%0d g=%0d b=%0d busy=%b ph=%0d done=%b pwm=%b%b%b",
                        $time, g.r, g.g, g.b, g.busy, g.phase, g.done,
                        g.pr, g.pg, g.pb, w.r, w.g, w.b, w.busy,
                        w.phase, w.done, w.pr, w.pg, w.pb);
                end
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [1:0] m);
        mode = m;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        int l;
        l = 0;
        seq.push_back(0);
        do begin
            l = (l + STP > MX) ? MX : l + STP;
            seq.push_back(l);
        end while (l != MX);
        do begin
            l = (l > STP) ? l - STP : 0;
            seq.push_back(l);
        end while (l != 0);
        blen = seq.size() - 1;

        cyc(3);
        rst = 1'b0;
        cyc(2);
        pulse_start(2'd1);
        cyc(45);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        pulse_start(2'd2);
        cyc(6);
        pause = 1'b1;
        cyc(10);
        pause = 1'b0;
        cyc(17);
        stop = 1'b1;
        start = 1'b1;
        pause = 1'b1;
        cyc(1);
        stop = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        cyc(2);
        pulse_start(2'd3);
        cyc(5);
        pulse_start(2'd0);
        mode = 2'd2;
        start = 1'b1;
        cyc(3);
        start = 1'b0;
        cyc(90);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(3);

        for (int i = 0; i < 5000; i++) begin
            start = ($urandom % 20) == 0;
            mode  = 2'($urandom % 4);
            pause = pause ? (($urandom % 4) != 0) : (($urandom % 25) == 0);
            stop  = ($urandom % 300) == 0;
            rst   = ($urandom % 1500) == 0;
            cyc(1);
        end
        start = 1'b0;
        pause = 1'b0;
        stop = 1'b0;
        rst = 1'b0;
        cyc(3);
        running = 1'b0;
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
